// File: rtl/zstd_frame_header_parser_if.sv
// rtl/zstd_frame_header_parser_if.sv - stream-in / header-record-out bundle for the frame header parser
// Optional feature macro: ZSTD_HDR_WINDOW_SIZE_EN (adds window_size)
interface zstd_frame_header_parser_if #(
  parameter int IN_BYTES = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*IN_BYTES-1:0] in_data;
  logic                  hdr_valid;
  logic                  hdr_ready;
  logic [7:0]            fhd;
  logic [7:0]            window_desc;
  logic [31:0]           dict_id;
  logic [63:0]           fcs;
  logic                  single_segment;
  logic                  checksum_flag;
  logic [4:0]            header_bytes;
  logic                  skippable;
  logic [31:0]           skip_size;
  logic                  err;
  logic [1:0]            err_code;
  logic [3:0]            rem_count;
  logic [8*IN_BYTES-1:0] rem_data;
`ifdef ZSTD_HDR_WINDOW_SIZE_EN
  logic [63:0]           window_size;
`endif

  // parser side
  modport master (
    input  in_valid, in_data, hdr_ready,
    output in_ready, hdr_valid, fhd, window_desc, dict_id, fcs, single_segment,
           checksum_flag, header_bytes, skippable, skip_size, err, err_code,
           rem_count, rem_data
`ifdef ZSTD_HDR_WINDOW_SIZE_EN
           , window_size
`endif
  );

  // stream source / record consumer side
  modport slave (
    output in_valid, in_data, hdr_ready,
    input  in_ready, hdr_valid, fhd, window_desc, dict_id, fcs, single_segment,
           checksum_flag, header_bytes, skippable, skip_size, err, err_code,
           rem_count, rem_data
`ifdef ZSTD_HDR_WINDOW_SIZE_EN
           , window_size
`endif
  );
endinterface

// File: rtl/zstd_frame_header_parser.sv
// rtl/zstd_frame_header_parser.sv - Zstandard frame / skippable-frame header parser
// Optional feature macro: ZSTD_HDR_WINDOW_SIZE_EN (window_size output, windowLog limit check)
module zstd_frame_header_parser #(
  parameter int IN_BYTES       = 2,
  parameter int MAX_WINDOW_LOG = 27
) (
  input  logic                       clk,
  input  logic                       reset,
  zstd_frame_header_parser_if.master bus
);
  localparam int LW = 8 * IN_BYTES;

  typedef enum logic [1:0] {COLLECT, EMIT, DRAIN_ERR} state_t;
  state_t state, state_nxt;

  // record registers double as the working copy while bytes arrive
  logic [5:0]    pos;
  logic [7:0]    r_fhd, r_wd;
  logic [31:0]   r_did, r_skip;
  logic [63:0]   r_fcs;
  logic          r_skippable, r_std_ok, r_skp_ok, r_err;
  logic [4:0]    r_hdr_len;
  logic [1:0]    r_code;
  logic [3:0]    r_rem_count;
  logic [LW-1:0] r_rem_data;

  logic accept, release_rec;

  // next values after folding in the current beat
  logic [7:0]    c_fhd, c_wd;
  logic [31:0]   c_did, c_skip;
  logic [63:0]   c_fcs;
  logic          c_skippable, c_std_ok, c_skp_ok, c_err, c_done;
  logic [4:0]    c_hdr_len;
  logic [1:0]    c_code;
  logic [3:0]    c_rem_count;
  logic [LW-1:0] c_rem_data;
  logic [5:0]    p;
  logic [4:0]    o;
  logic [7:0]    b, std_b, skp_b;

  function automatic logic [4:0] wd_len(input logic [7:0] f);
    return {4'd0, ~f[5]};
  endfunction

  function automatic logic [4:0] did_len(input logic [7:0] f);
    case (f[1:0])
      2'd0:    return 5'd0;
      2'd1:    return 5'd1;
      2'd2:    return 5'd2;
      default: return 5'd4;
    endcase
  endfunction

  function automatic logic [4:0] fcs_len(input logic [7:0] f);
    case (f[7:6])
      2'd0:    return {4'd0, f[5]};
      2'd1:    return 5'd2;
      2'd2:    return 5'd4;
      default: return 5'd8;
    endcase
  endfunction

  assign accept      = bus.in_valid && (state == COLLECT);
  assign release_rec = (state != COLLECT) && bus.hdr_ready;

  // walk the lanes of the beat in stream order; stop at the last header byte or first error
  always_comb begin
    c_fhd       = r_fhd;
    c_wd        = r_wd;
    c_did       = r_did;
    c_skip      = r_skip;
    c_fcs       = r_fcs;
    c_skippable = r_skippable;
    c_std_ok    = r_std_ok;
    c_skp_ok    = r_skp_ok;
    c_hdr_len   = r_hdr_len;
    c_err       = 1'b0;
    c_code      = 2'd0;
    c_done      = 1'b0;
    c_rem_count = 4'd0;
    c_rem_data  = '0;
    p           = '0;
    o           = '0;
    b           = '0;
    std_b       = '0;
    skp_b       = '0;
    for (int i = 0; i < IN_BYTES; i++) begin
      if (!c_done && !c_err) begin
        p = pos + 6'(i);
        b = bus.in_data[8*i +: 8];
        o = 5'(p - 6'd5);
        if (p < 6'd4) begin
          case (p[1:0])
            2'd0:    begin std_b = 8'h28; skp_b = 8'h50; end
            2'd1:    begin std_b = 8'hB5; skp_b = 8'h2A; end
            2'd2:    begin std_b = 8'h2F; skp_b = 8'h4D; end
            default: begin std_b = 8'hFD; skp_b = 8'h18; end
          endcase
          if (b != std_b) c_std_ok = 1'b0;
          if ((p == 6'd0) ? (b[7:4] != 4'h5) : (b != skp_b)) c_skp_ok = 1'b0;
          if (!c_std_ok && !c_skp_ok) begin
            c_err  = 1'b1;
            c_code = 2'd1;
          end else if (p == 6'd3 && c_skp_ok) begin
            c_skippable = 1'b1;
            c_hdr_len   = 5'd8;
          end
        end else if (c_skippable) begin
          c_skip = c_skip | ({24'd0, b} << {p[1:0], 3'b000});
        end else if (p == 6'd4) begin
          c_fhd     = b;
          c_hdr_len = 5'd5 + wd_len(b) + did_len(b) + fcs_len(b);
          if (b[3]) begin
            c_err  = 1'b1;
            c_code = 2'd2;
          end
        end else if (o < wd_len(c_fhd)) begin
          c_wd = b;
`ifdef ZSTD_HDR_WINDOW_SIZE_EN
          if (int'(b[7:3]) + 10 > MAX_WINDOW_LOG) begin
            c_err  = 1'b1;
            c_code = 2'd3;
          end
`endif
        end else if (o < wd_len(c_fhd) + did_len(c_fhd)) begin
          c_did = c_did | ({24'd0, b} << {2'(o - wd_len(c_fhd)), 3'b000});
        end else begin
          c_fcs = c_fcs | ({56'd0, b} << {3'(o - wd_len(c_fhd) - did_len(c_fhd)), 3'b000});
        end
        if (!c_err && c_hdr_len != 5'd0 && {1'b0, c_hdr_len} == p + 6'd1) begin
          c_done      = 1'b1;
          c_rem_count = 4'(IN_BYTES - 1 - i);
          c_rem_data  = bus.in_data >> (8 * (i + 1));
          // the two-byte FCS form is stored offset by 256
          if (!c_skippable && fcs_len(c_fhd) == 5'd2) c_fcs = c_fcs + 64'd256;
        end
      end
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= COLLECT;
    else        state <= state_nxt;
  end

  // next state and handshake outputs
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.hdr_valid = 1'b0;
    case (state)
      COLLECT: begin
        bus.in_ready = 1'b1;
        if (accept) begin
          if (c_err)       state_nxt = DRAIN_ERR;
          else if (c_done) state_nxt = EMIT;
        end
      end
      EMIT, DRAIN_ERR: begin
        bus.hdr_valid = 1'b1;
        if (bus.hdr_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // record / position registers; cleared on reset and when a record is released
  always_ff @(posedge clk) begin
    if (!reset || release_rec) begin
      pos         <= '0;
      r_fhd       <= '0;
      r_wd        <= '0;
      r_did       <= '0;
      r_skip      <= '0;
      r_fcs       <= '0;
      r_skippable <= 1'b0;
      r_std_ok    <= 1'b1;
      r_skp_ok    <= 1'b1;
      r_hdr_len   <= '0;
      r_err       <= 1'b0;
      r_code      <= '0;
      r_rem_count <= '0;
      r_rem_data  <= '0;
    end else if (accept) begin
      pos         <= pos + 6'(IN_BYTES);
      r_fhd       <= c_fhd;
      r_wd        <= c_wd;
      r_did       <= c_did;
      r_skip      <= c_skip;
      r_fcs       <= c_fcs;
      r_skippable <= c_skippable;
      r_std_ok    <= c_std_ok;
      r_skp_ok    <= c_skp_ok;
      r_hdr_len   <= c_hdr_len;
      r_err       <= c_err;
      r_code      <= c_code;
      r_rem_count <= c_rem_count;
      r_rem_data  <= c_rem_data;
    end
  end

  assign bus.fhd            = r_fhd;
  assign bus.window_desc    = r_wd;
  assign bus.dict_id        = r_did;
  assign bus.fcs            = r_fcs;
  assign bus.single_segment = r_fhd[5];
  assign bus.checksum_flag  = r_fhd[2];
  assign bus.header_bytes   = r_hdr_len;
  assign bus.skippable      = r_skippable;
  assign bus.skip_size      = r_skip;
  assign bus.err            = r_err;
  assign bus.err_code       = r_code;
  assign bus.rem_count      = r_rem_count;
  assign bus.rem_data       = r_rem_data;

`ifdef ZSTD_HDR_WINDOW_SIZE_EN
  logic [63:0] ws_base;
  assign ws_base         = 64'd1 << (6'd10 + {1'b0, r_wd[7:3]});
  assign bus.window_size = (state == COLLECT) ? 64'd0 :
                           r_fhd[5] ? r_fcs : ws_base + (ws_base >> 3) * {61'd0, r_wd[2:0]};
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_WINDOW_LOG > 0);
`endif
endmodule

// File: tb/tb_zstd_frame_header_parser.sv
// tb/tb_zstd_frame_header_parser.sv - scoreboard bench for zstd_frame_header_parser at 2, 4 and 8 bytes per beat
module tb_zstd_frame_header_parser;
  logic        clk = 1'b0;
  logic        reset;
  logic        d_valid;
  logic [63:0] d_data;
  logic        hdr_ready;
  int          sel;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  zstd_frame_header_parser_if #(.IN_BYTES(2)) if2 ();
  zstd_frame_header_parser_if #(.IN_BYTES(4)) if4 ();
  zstd_frame_header_parser_if #(.IN_BYTES(8)) if8 ();

  assign if2.in_valid  = d_valid && (sel == 0);
  assign if4.in_valid  = d_valid && (sel == 1);
  assign if8.in_valid  = d_valid && (sel == 2);
  assign if2.in_data   = d_data[15:0];
  assign if4.in_data   = d_data[31:0];
  assign if8.in_data   = d_data;
  assign if2.hdr_ready = hdr_ready;
  assign if4.hdr_ready = hdr_ready;
  assign if8.hdr_ready = hdr_ready;

  zstd_frame_header_parser #(.IN_BYTES(2), .MAX_WINDOW_LOG(27)) u2 (.clk(clk), .reset(reset), .bus(if2));
  zstd_frame_header_parser #(.IN_BYTES(4), .MAX_WINDOW_LOG(27)) u4 (.clk(clk), .reset(reset), .bus(if4));
  zstd_frame_header_parser #(.IN_BYTES(8), .MAX_WINDOW_LOG(27)) u8 (.clk(clk), .reset(reset), .bus(if8));

  logic        m_in_ready, m_hdr_valid, m_ss, m_cs, m_skp, m_err;
  logic [7:0]  m_fhd, m_wd;
  logic [31:0] m_did, m_skip;
  logic [63:0] m_fcs, m_rem, m_ws;
  logic [4:0]  m_hb;
  logic [1:0]  m_code;
  logic [3:0]  m_rc;

  always_comb begin
    m_ws = 64'd0;
    case (sel)
      1: begin
        m_in_ready = if4.in_ready; m_hdr_valid = if4.hdr_valid; m_ss = if4.single_segment;
        m_cs = if4.checksum_flag; m_skp = if4.skippable; m_err = if4.err; m_fhd = if4.fhd;
        m_wd = if4.window_desc; m_did = if4.dict_id; m_skip = if4.skip_size; m_fcs = if4.fcs;
        m_rem = {32'd0, if4.rem_data}; m_hb = if4.header_bytes; m_code = if4.err_code; m_rc = if4.rem_count;
`ifdef ZSTD_HDR_WINDOW_SIZE_EN
        m_ws = if4.window_size;
`endif
      end
      2: begin
        m_in_ready = if8.in_ready; m_hdr_valid = if8.hdr_valid; m_ss = if8.single_segment;
        m_cs = if8.checksum_flag; m_skp = if8.skippable; m_err = if8.err; m_fhd = if8.fhd;
        m_wd = if8.window_desc; m_did = if8.dict_id; m_skip = if8.skip_size; m_fcs = if8.fcs;
        m_rem = if8.rem_data; m_hb = if8.header_bytes; m_code = if8.err_code; m_rc = if8.rem_count;
`ifdef ZSTD_HDR_WINDOW_SIZE_EN
        m_ws = if8.window_size;
`endif
      end
      default: begin
        m_in_ready = if2.in_ready; m_hdr_valid = if2.hdr_valid; m_ss = if2.single_segment;
        m_cs = if2.checksum_flag; m_skp = if2.skippable; m_err = if2.err; m_fhd = if2.fhd;
        m_wd = if2.window_desc; m_did = if2.dict_id; m_skip = if2.skip_size; m_fcs = if2.fcs;
        m_rem = {48'd0, if2.rem_data}; m_hb = if2.header_bytes; m_code = if2.err_code; m_rc = if2.rem_count;
`ifdef ZSTD_HDR_WINDOW_SIZE_EN
        m_ws = if2.window_size;
`endif
      end
    endcase
  end

  typedef struct packed {
    logic        err;
    logic [1:0]  code;
    logic [7:0]  fhd;
    logic [7:0]  wd;
    logic [31:0] did;
    logic [31:0] skip;
    logic [63:0] fcs;
    logic [63:0] ws;
    logic [63:0] rem;
    logic [4:0]  hb;
    logic [3:0]  rc;
    logic        skp;
    logic        chk_ws;
  } rec_t;

  rec_t exp_q[$];
  rec_t mon_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push_ok(input logic [7:0] fhd, input logic [7:0] wd, input logic [31:0] did,
                         input logic [63:0] fcs, input logic [4:0] hb, input logic [3:0] rc,
                         input logic [63:0] rem, input logic [63:0] ws);
    rec_t r;
    r = '0;
    r.fhd = fhd; r.wd = wd; r.did = did; r.fcs = fcs; r.hb = hb; r.rc = rc; r.rem = rem;
    r.ws = ws; r.chk_ws = 1'b1;
    exp_q.push_back(r);
  endtask

  task automatic push_err(input logic [1:0] code, input logic [7:0] fhd);
    rec_t r;
    r = '0;
    r.err = 1'b1; r.code = code; r.fhd = fhd;
    exp_q.push_back(r);
  endtask

  // pops one expectation per released record
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (reset && m_hdr_valid && hdr_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_record", 64'(m_hdr_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("err", 64'(m_err), 64'(mon_e.err));
          chk("err_code", 64'(m_code), 64'(mon_e.code));
          chk("rem_count", 64'(m_rc), 64'(mon_e.rc));
          chk("skippable", 64'(m_skp), 64'(mon_e.skp));
          if (!mon_e.err) begin
            chk("fhd", 64'(m_fhd), 64'(mon_e.fhd));
            chk("window_desc", 64'(m_wd), 64'(mon_e.wd));
            chk("dict_id", 64'(m_did), 64'(mon_e.did));
            chk("fcs", m_fcs, mon_e.fcs);
            chk("header_bytes", 64'(m_hb), 64'(mon_e.hb));
            chk("skip_size", 64'(m_skip), 64'(mon_e.skip));
            chk("rem_data", m_rem, mon_e.rem);
            chk("single_segment", 64'(m_ss), 64'(mon_e.fhd[5]));
            chk("checksum_flag", 64'(m_cs), 64'(mon_e.fhd[2]));
`ifdef ZSTD_HDR_WINDOW_SIZE_EN
            if (mon_e.chk_ws) chk("window_size", m_ws, mon_e.ws);
`endif
          end else if (mon_e.code == 2'd2) begin
            chk("err_fhd", 64'(m_fhd), 64'(mon_e.fhd));
          end
        end
      end
    end
  endtask

  task automatic send_beat(input logic [63:0] d);
    int n;
    n = 0;
    d_valid = 1'b1;
    d_data  = d;
    @(negedge clk);
    while (!m_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!m_in_ready) chk("in_ready_timeout", 64'(m_in_ready), 64'd1);
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    d_data  = '0;
  endtask

  // v holds the stream with the earliest byte in the most significant used position
  task automatic send_frame(input logic [191:0] v, input int n);
    int ib;
    logic [63:0] d;
    ib = 2 << sel;
    for (int j = 0; j < n / ib; j++) begin
      d = '0;
      for (int l = 0; l < ib; l++) d[8*l +: 8] = v[8*(n-1-(j*ib+l)) +: 8];
      send_beat(d);
    end
    chk("latency_hdr_valid", 64'(m_hdr_valid), 64'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    d_valid   = 1'b0;
    d_data    = '0;
    hdr_ready = 1'b1;
    sel       = 0;
    fork
      monitor_loop();
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 64'(m_in_ready), 64'd1);
    chk("reset_hdr_valid", 64'(m_hdr_valid), 64'd0);
    chk("reset_err", 64'(m_err), 64'd0);
    chk("reset_fcs", m_fcs, 64'd0);
    chk("reset_header_bytes", 64'(m_hb), 64'd0);
    chk("reset_rem_count", 64'(m_rc), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 2 bytes per beat
    sel = 0;
    push_ok(8'h20, 8'h00, 32'd0, 64'd5, 5'd6, 4'd0, 64'd0, 64'd5);
    send_frame(192'h28B52FFD2005, 6);
    wait_drain();
    push_ok(8'h60, 8'h00, 32'd0, 64'h1334, 5'd7, 4'd1, 64'hAA, 64'h1334);
    send_frame(192'h28B52FFD603412AA, 8);
    wait_drain();
    push_err(2'd1, 8'h00);
    send_frame(192'h28B52FFE, 4);
    wait_drain();
    push_err(2'd2, 8'h28);
    send_frame(192'h28B52FFD2800, 6);
    wait_drain();
`ifdef ZSTD_HDR_WINDOW_SIZE_EN
    push_err(2'd3, 8'h00);
    send_frame(192'h28B52FFD0090, 6);
    wait_drain();
`endif

    // record held while the consumer stalls; input beats are ignored meanwhile
    hdr_ready = 1'b0;
    push_ok(8'h60, 8'h00, 32'd0, 64'h1334, 5'd7, 4'd1, 64'hAA, 64'h1334);
    send_frame(192'h28B52FFD603412AA, 8);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      d_valid = 1'b1;
      d_data  = 64'hFFFF;
      chk("hold_in_ready", 64'(m_in_ready), 64'd0);
      chk("hold_hdr_valid", 64'(m_hdr_valid), 64'd1);
      chk("hold_fcs", m_fcs, 64'h1334);
      chk("hold_rem_data", m_rem, 64'hAA);
    end
    d_valid = 1'b0;
    d_data  = '0;
    @(posedge clk);
    #1;
    hdr_ready = 1'b1;
    wait_drain();

    // reset in the middle of a header abandons it
    send_beat(64'hB528);
    send_beat(64'hFD2F);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("reset_abandon_hdr_valid", 64'(m_hdr_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    push_ok(8'h20, 8'h00, 32'd0, 64'd5, 5'd6, 4'd0, 64'd0, 64'd5);
    send_frame(192'h28B52FFD2005, 6);
    wait_drain();

    // 4 bytes per beat
    sel = 1;
    push_ok(8'h03, 8'h58, 32'h12345678, 64'd0, 5'd10, 4'd2, 64'hC2C1, 64'h200000);
    send_frame(192'h28B52FFD035878563412C1C2, 12);
    wait_drain();

    // 8 bytes per beat: skippable frame, then the longest standard header
    sel = 2;
    begin
      rec_t r;
      r = '0;
      r.skp = 1'b1; r.skip = 32'd16; r.hb = 5'd8;
      exp_q.push_back(r);
    end
    send_frame(192'h502A4D1810000000, 8);
    wait_drain();
    push_ok(8'hC7, 8'h08, 32'h44332211, 64'h0807060504030201, 5'd18, 4'd6, 64'hD6D5D4D3D2D1, 64'h800);
    send_frame(192'h28B52FFDC708112233440102030405060708D1D2D3D4D5D6, 24);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
